imem_loader: RTL and testbench

- Writer side of the instruction memory that the IF stage reads.
- Accepts a byte stream over a valid/ready handshake and packs four bytes per word, big-endian, to match MIPS fetch order.
- Writes each word into the instruction RAM write port at consecutive word addresses from 0.
- Holds the CPU pipeline in reset through `cpu_rst_n` while a load is in progress, then releases it so fetch starts at PC 0.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 217 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-RAM write bundle for imem_loader.
// master: host side (drives start, load_len and the byte stream).
// slave : loader side (drives byte_ready, RAM write port, CPU reset and status).
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, load_len, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err
  );

  modport slave (
    input  start, load_len, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream big-endian into 32-bit words,
// writes them to consecutive RAM word addresses from 0 and holds the CPU
// pipeline in reset while loading.
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic [31:0]       word_ins;
  logic [ADDR_W:0]   len_sat;

  // Saturate the requested length to the RAM depth so the address never wraps.
  assign len_sat   = bus.load_len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : bus.load_len;
  assign accept    = bus.byte_valid && byte_ready_q;
  assign start_ok  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_word = ({1'b0, word_cnt_q} == (len_q - {{ADDR_W{1'b0}}, 1'b1}));

  // Insert the incoming byte at its big-endian lane (byte 0 -> bits 31:24).
  always_comb begin
    word_ins = word_q;
    case (byte_cnt_q)
      2'd0:    word_ins[31:24] = bus.byte_data;
      2'd1:    word_ins[23:16] = bus.byte_data;
      2'd2:    word_ins[15:8]  = bus.byte_data;
      default: word_ins[7:0]   = bus.byte_data;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    byte_ready_d = byte_ready_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d        = err_q;
    csum_d       = csum_q;
`endif

    case (state_q)
      IDLE: begin
        // Out of reset with no load requested, let the CPU run existing RAM.
        cpu_rst_n_d = 1'b1;
      end

      RECV: begin
        if (len_q == '0) begin
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          byte_ready_d = 1'b0;
          cpu_rst_n_d  = 1'b1;
        end else if (accept) begin
          word_d     = word_ins;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.byte_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d      = WRITE;
            byte_ready_d = 1'b0;
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q;
            imem_wdata_d = word_ins;
          end
        end
      end

      WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d      = CHK;
          byte_ready_d = 1'b1;
`else
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cpu_rst_n_d  = 1'b1;
`endif
        end else begin
          word_cnt_d   = word_cnt_q + 1'b1;
          byte_ready_d = 1'b1;
          state_d      = RECV;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        // A bad trailer leaves the CPU in reset until a clean reload.
        if (accept) begin
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          byte_ready_d = 1'b0;
          err_d        = (bus.byte_data != csum_q);
          cpu_rst_n_d  = (bus.byte_data == csum_q);
        end
      end
`endif

      default: begin
      end
    endcase

    // Start is honoured only when idle or finished; it overrides the above.
    if (start_ok) begin
      state_d      = RECV;
      len_d        = len_sat;
      word_cnt_d   = '0;
      byte_cnt_d   = 2'd0;
      imem_addr_d  = '0;
      done_d       = 1'b0;
      busy_d       = 1'b1;
      cpu_rst_n_d  = 1'b0;
      byte_ready_d = (len_sat != '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_d        = 1'b0;
      csum_d       = 8'h00;
`endif
    end
  end

  // State and output registers; reset forces IDLE and holds the CPU in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'h0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q        <= 1'b0;
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q        <= err_d;
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads plus hand-written
// stall, saturation, mid-load start, mid-load reset and checksum sequences.
// Expected RAM writes go to a scoreboard queue as bytes are driven.
module tb_imem_loader;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [AW:0] len;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  wr_t         exp_q[$];
  logic [31:0] words_q[$];
  vec_t        vecs[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_we_cyc = -1;
  bit spacing_on = 0;
  int start_glitch_at = -1;
  logic [AW-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM write is matched against the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("write_data", bus.imem_wdata, e.data);
        $display("write addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
      end
      chk("cpu_held_during_write", 32'(bus.cpu_rst_n), 32'd0);
      if (spacing_on && last_we_cyc >= 0)
        chk("write_spacing", 32'(cyc - last_we_cyc), 32'd5);
      last_we_cyc = cyc;
      last_addr   = bus.imem_addr;
      wr_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the loader accepts it (bounded).
  task automatic send_byte(input logic [7:0] b);
    bit taken;
    taken = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        tick();
        taken = 1;
        break;
      end
    end
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got byte_ready=0 expected byte %h accepted", b);
    end
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    bus.start    = 1'b1;
    bus.load_len = len;
    tick();
    bus.start    = 1'b0;
  endtask

  // Wait for done within limit cycles; the bound itself is a comparison.
  task automatic wait_done(input string name, input int limit);
    bit got;
    got = 0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: got done=0 expected done=1 within %0d cycles", name, limit);
    end
  endtask

  // Complete load of words_q with len; bad selects a corrupted trailer.
  task automatic run_load(input string name, input logic [AW:0] len, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    int         n;
    wr_t        e;
    x = 8'h00;
    n = words_q.size();
    wr_count    = 0;
    last_we_cyc = -1;
    spacing_on  = 1;
    pulse_start(len);
    @(negedge clk);
    chk({name, "_busy"}, 32'(bus.busy), 32'd1);
    chk({name, "_cpu_held"}, 32'(bus.cpu_rst_n), 32'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      e.addr = i[AW-1:0];
      e.data = words_q[i];
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        b = words_q[i][31-8*k -: 8];
        x = x ^ b;
        if (start_glitch_at == i * 4 + k) begin
          bus.start    = 1'b1;
          bus.load_len = 9'd5;
        end
        send_byte(b);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n > 0) send_byte(x ^ {7'b0, bad});
`endif
    wait_done({name, "_done"}, (n == 0) ? 1 : 12);
    chk({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({name, "_byte_ready_end"}, 32'(bus.byte_ready), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({name, "_err"}, 32'(bus.err), 32'(bad));
    chk({name, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'(!bad));
`else
    chk({name, "_err"}, 32'(bus.err), 32'd0);
    chk({name, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'd1);
`endif
    chk({name, "_write_count"}, 32'(wr_count), 32'(n));
    chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    $display("load %s len=%0d words=%0d done=%b err=%b cpu_rst_n=%b", name, len, n, bus.done, bus.err, bus.cpu_rst_n);
    spacing_on = 0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sb[4];
    int         pat[7];
    int         idx;
    wr_t        e;

    vecs[0] = '{9'd2, 2, 32'h3C081234, 32'h20090005, 32'h0};
    vecs[1] = '{9'd1, 1, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[2] = '{9'd3, 3, 32'h00000000, 32'hFFFFFFFF, 32'hA5A55A5A};
    vecs[3] = '{9'd0, 0, 32'h0, 32'h0, 32'h0};

    bus.start = 1'b0;
    bus.load_len = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;

    // Reset values, then release and idle.
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
    chk("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("cpu_rst_n_before_edge", 32'(bus.cpu_rst_n), 32'd0);
    tick();
    @(negedge clk);
    chk("cpu_rst_n_one_clock", 32'(bus.cpu_rst_n), 32'd1);
    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    $display("reset released cpu_rst_n=%b busy=%b done=%b", bus.cpu_rst_n, bus.busy, bus.done);
    tick();

    // Table of loads with byte_valid held high.
    for (int v = 0; v < 4; v++) begin
      words_q.delete();
      if (vecs[v].n > 0) words_q.push_back(vecs[v].w0);
      if (vecs[v].n > 1) words_q.push_back(vecs[v].w1);
      if (vecs[v].n > 2) words_q.push_back(vecs[v].w2);
      run_load($sformatf("vec%0d", v), vecs[v].len, 1'b0);
    end

    // Stalled source: valid pattern 1,0,0,1,1,0,1, junk data while invalid.
    sb  = '{8'h11, 8'h22, 8'h33, 8'h44};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    wr_count    = 0;
    last_we_cyc = -1;
    e.addr = '0;
    e.data = 32'h11223344;
    exp_q.push_back(e);
    pulse_start(9'd1);
    idx = 0;
    for (int p = 0; p < 12 && idx < 4; p++) begin
      if (p < 7 && pat[p] == 0) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hEE;
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = sb[idx];
      end
      @(negedge clk);
      if (bus.byte_valid && bus.byte_ready) idx++;
      tick();
    end
    bus.byte_valid = 1'b0;
    chk("stall_bytes_taken", 32'(idx), 32'd4);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    wait_done("stall_done", 12);
    chk("stall_write_count", 32'(wr_count), 32'd1);
    chk("stall_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("load stall writes=%0d done=%b", wr_count, bus.done);
    tick();

    // Oversized length saturates to the RAM depth.
    words_q.delete();
    for (int i = 0; i < (1 << AW); i++)
      words_q.push_back({i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'h3C});
    run_load("saturate", 9'((1 << AW) + 5), 1'b0);
    chk("saturate_last_addr", 32'(last_addr), 32'((1 << AW) - 1));

    // Start pulsed in the middle of a load is ignored.
    words_q.delete();
    words_q.push_back(32'hA1B2C3D4);
    words_q.push_back(32'h0BADF00D);
    start_glitch_at = 2;
    run_load("start_midload", 9'd2, 1'b0);
    start_glitch_at = -1;

    // Reset after 6 bytes of a 3-word load.
    wr_count = 0;
    pulse_start(9'd3);
    e.addr = 8'd0;
    e.data = 32'h01234567;
    exp_q.push_back(e);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
    e.addr = 8'd1;
    e.data = 32'h89ABCDEF;
    exp_q.push_back(e);
    send_byte(8'h89); send_byte(8'hAB);
    rst_n = 1'b0;
    #1;
    chk("midrst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("midrst_write_count", 32'(wr_count), 32'd1);
    chk("midrst_pending_words", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_cpu_release", 32'(bus.cpu_rst_n), 32'd1);
    chk("midrst_idle_done", 32'(bus.done), 32'd0);
    $display("midload reset writes=%0d cpu_rst_n=%b", wr_count, bus.cpu_rst_n);
    tick();
    words_q.delete();
    words_q.push_back(32'hCAFEF00D);
    run_load("reload", 9'd1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailer checksum good, bad, then a clean reload releases the CPU.
    words_q.delete();
    words_q.push_back(32'h01020304);
    run_load("csum_good", 9'd1, 1'b0);
    run_load("csum_bad", 9'd1, 1'b1);
    repeat (3) @(negedge clk);
    chk("csum_bad_cpu_held", 32'(bus.cpu_rst_n), 32'd0);
    chk("csum_bad_err_held", 32'(bus.err), 32'd1);
    tick();
    run_load("csum_recover", 9'd1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
